univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
Parametrised universal shift register. It is the next generation of the team's fixed 4-stage, 1-bit serial-in/serial-out delay line.
- DEPTH stages, each WIDTH bits wide.
- Modes: hold, shift right, shift left, parallel load.
- Synchronous clear and global enable.
- Fill counter/full flag so downstream logic knows when a complete word has been shifted in serially. This makes the block usable as SISO, SIPO, PISO or PIPO in serial-link and deserializer paths.

Parameters:
WIDTH, 1, bits per stage (>=1)
DEPTH, 4, number of stages (>=2)
CNT_W, $clog2(DEPTH+1), width of fill_cnt (derived localparam, not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; when 0, all state holds (clr still acts)
clr  input  1  synchronous clear; priority over en and mode
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
sin_r  input  WIDTH  serial data entering stage 0 on shift right
sin_l  input  WIDTH  serial data entering stage DEPTH-1 on shift left
pin  input  WIDTH*DEPTH  parallel load data; stage i = pin[i*WIDTH +: WIDTH]
pout  output  WIDTH*DEPTH  all stages, same packing as pin
sout_r  output  WIDTH  stage DEPTH-1 (right-shift serial out)
sout_l  output  WIDTH  stage 0 (left-shift serial out)
fill_cnt  output  CNT_W  consecutive same-direction shifts, saturating at DEPTH
full  output  1  fill_cnt == DEPTH

Behaviour:
- Reset (rst_n low, asynchronous): all stages, fill_cnt, full, last_dir = 0, so pout, sout_r and sout_l = 0. Release is synchronous to the next clk edge. Reset mid-shift discards the data in flight.
- Precedence per rising edge:
  - clr=1: stages, fill_cnt and last_dir cleared.
  - else en=0: hold everything.
  - else apply mode.
- Shift right: stage0<=sin_r; stage[i]<=stage[i-1].
- Shift left: stage[DEPTH-1]<=sin_l; stage[i]<=stage[i+1].
- Parallel load: all stages <= pin in one cycle; fill_cnt<=0.
- Hold (mode 00): no change.
- Latency and outputs:
  - A value on sin_r appears on sout_r after exactly DEPTH enabled shift-right edges. Cycles with en=0 do not count.
  - All outputs are registered; there is no combinational input-to-output path.
  - DEPTH=4, WIDTH=1, en=1, mode=01 reproduces the legacy 4-cycle delay line exactly.
- fill_cnt:
  - On a shift in the same direction as last_dir: increment, saturating at DEPTH.
  - On a direction change: set to 1 and update last_dir.
  - The first shift after reset, clr or load counts as 1 in either direction.
- full: registered with fill_cnt. It stays high while shifting continues in the same direction (saturation) and drops on load, clr or direction change.
- Mode 11 with en=1 and clr=1 gives clear, not load.

Optional Feature:
USR_ROTATE_EN
- Defined: adds input port rot (1 bit). In shift modes with rot=1, the incoming data is the outgoing stage instead of the serial input:
  - right: stage0<=stage[DEPTH-1]
  - left: stage[DEPTH-1]<=stage0
  - fill_cnt and last_dir are unchanged during a rotate.
  - rot is ignored in hold and load.
- Not defined: no rot port; shifts always take sin_r/sin_l.

Decomposition:
- Package usr_pkg:
  - enum typedef usr_mode_e (USR_HOLD, USR_SHR, USR_SHL, USR_LOAD) on 2 bits.
  - Direction constants DIR_R/DIR_L.
- Sub-module usr_stage: one WIDTH-bit stage with async active-low reset, a clr input, and a 4:1 next-value mux (hold / left neighbour / right neighbour / parallel bit). It is instantiated DEPTH times in a generate loop, as the successor of the single D flip-flop cell.
- The fill counter and full logic live in the top level.

Test Plan:
1. DEPTH=4, WIDTH=1, mode=01, en=1, sin_r pattern 1,0,1,1 -> sout_r shows 1,0,1,1 on edges 4..7; full rises after edge 4, with fill_cnt=4.
2. WIDTH=8, load pin=0x44_33_22_11, then 4 shift-right edges with sin_r=0 -> sout_r reads 0x44, 0x33, 0x22, 0x11 (one per edge, sampled before each shift); fill_cnt goes 0,1,2,3,4.
3. Shift right 3 times, then shift left once -> fill_cnt=1, full=0; stage DEPTH-1 = sin_l.
4. en=0 for 5 cycles mid-stream -> pout, fill_cnt and full frozen; the shift resumes with no data loss.
5. rst_n pulsed low asynchronously between edges while full=1 -> all outputs 0 immediately, with no clock; clr=1 with mode=11 -> stages 0, load ignored.
6. With USR_ROTATE_EN: load 0x1 (DEPTH=4, WIDTH=1), rot=1, 4 shift-right edges -> pout goes 0x2, 0x4, 0x8, 0x1; fill_cnt stays 0.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operating modes and the
// shift-direction encoding used by the fill counter.
package usr_pkg;

  typedef enum logic [1:0] {
    USR_HOLD = 2'b00,
    USR_SHR  = 2'b01,
    USR_SHL  = 2'b10,
    USR_LOAD = 2'b11
  } usr_mode_e;

  // Reset value of last_dir is DIR_R, so the first right shift increments 0->1.
  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle for univ_shift_reg. The rot input exists only when
// USR_ROTATE_EN is defined.
interface univ_shift_reg_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   en;
  logic                   clr;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       sin_r;
  logic [WIDTH-1:0]       sin_l;
  logic [WIDTH*DEPTH-1:0] pin;
`ifdef USR_ROTATE_EN
  logic                   rot;
`endif
  logic [WIDTH*DEPTH-1:0] pout;
  logic [WIDTH-1:0]       sout_r;
  logic [WIDTH-1:0]       sout_l;
  logic [CNT_W-1:0]       fill_cnt;
  logic                   full;

  modport master (
`ifdef USR_ROTATE_EN
    output rot,
`endif
    output en, clr, mode, sin_r, sin_l, pin,
    input  pout, sout_r, sout_l, fill_cnt, full
  );

  modport slave (
`ifdef USR_ROTATE_EN
    input  rot,
`endif
    input  en, clr, mode, sin_r, sin_l, pin,
    output pout, sout_r, sout_l, fill_cnt, full
  );

endinterface

// File: rtl/usr_stage.sv
// One WIDTH-bit register stage: clear, then 4:1 mux of hold / left
// neighbour / right neighbour / parallel data.
module usr_stage
  import usr_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  usr_mode_e        sel,
  input  logic [WIDTH-1:0] from_l,
  input  logic [WIDTH-1:0] from_r,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else begin
      unique case (sel)
        USR_SHR:  q_d = from_l;
        USR_SHL:  q_d = from_r;
        USR_LOAD: q_d = pin;
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH x WIDTH stages with hold/shift/load, sync
// clear, enable and a saturating same-direction fill counter.
// Define USR_ROTATE_EN to add the rot input (circular shifts).
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  univ_shift_reg_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] stg;
  logic [WIDTH-1:0]            in_r, in_l;
  usr_mode_e                   mode, sel;
  logic                        rot;
  logic                        shift_dir;

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             dir_d, dir_q;
  logic             full_d, full_q;

  assign mode = usr_mode_e'(bus.mode);
`ifdef USR_ROTATE_EN
  assign rot  = bus.rot;
`else
  assign rot  = 1'b0;
`endif

  // Enable is folded into the stage mux select; clr is handled in each stage.
  assign sel  = bus.en ? mode : USR_HOLD;
  assign in_r = rot ? stg[DEPTH-1] : bus.sin_r;
  assign in_l = rot ? stg[0]       : bus.sin_l;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic [WIDTH-1:0] from_l, from_r;
    if (i == 0) begin : g_first
      assign from_l = in_r;
    end else begin : g_mid_l
      assign from_l = stg[i-1];
    end
    if (i == DEPTH - 1) begin : g_last
      assign from_r = in_l;
    end else begin : g_mid_r
      assign from_r = stg[i+1];
    end

    usr_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (bus.clr),
      .sel    (sel),
      .from_l (from_l),
      .from_r (from_r),
      .pin    (bus.pin[i*WIDTH +: WIDTH]),
      .q      (stg[i])
    );
  end

  assign shift_dir = (mode == USR_SHL) ? DIR_L : DIR_R;

  // Rotates move data but leave the run length and direction untouched.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (bus.clr) begin
      cnt_d = '0;
      dir_d = DIR_R;
    end else if (bus.en) begin
      unique case (mode)
        USR_SHR, USR_SHL: begin
          if (!rot) begin
            if (shift_dir == dir_q) begin
              if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
            end else begin
              cnt_d = CNT_W'(1);
              dir_d = shift_dir;
            end
          end
        end
        USR_LOAD: cnt_d = '0;
        default:  cnt_d = cnt_q;
      endcase
    end
    full_d = (cnt_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dir_q  <= DIR_R;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      full_q <= full_d;
    end
  end

  assign bus.pout     = stg;
  assign bus.sout_r   = stg[DEPTH-1];
  assign bus.sout_l   = stg[0];
  assign bus.fill_cnt = cnt_q;
  assign bus.full     = full_q;

endmodule
